// File: rtl/psram_bus_arbiter.sv
// rtl/psram_bus_arbiter.sv - PSRAM pin/engine arbiter for LCD fetch, FPGA write and external MCU
module psram_bus_arbiter #(
  parameter int TURN_CYC = 4,
  parameter int MAX_SKIP = 8,
  parameter int MCU_TMO  = 4096
) (
  input  logic       SYS_CLK,
  input  logic       SYS_RSTn,
  input  logic       lcd_req,
  output logic       lcd_gnt,
  input  logic       lcd_done,
  input  logic       wr_req,
  output logic       wr_gnt,
  input  logic       wr_done,
  input  logic       MCU_REQ,
  output logic       MCU_ACK,
  output logic       psram_ctrl,
  output logic [1:0] eng_sel,
  output logic       lcd_underrun,
  input  logic       underrun_clr
);

  localparam int TURN_W = $clog2(TURN_CYC + 1);
  localparam int SKIP_W = $clog2(MAX_SKIP + 1);
  localparam int TMO_W  = $clog2(MCU_TMO + 1);

  localparam logic [TURN_W-1:0] TURN_LAST = TURN_W'(TURN_CYC);
  localparam logic [TURN_W-1:0] TURN_ONE  = TURN_W'(1);
  localparam logic [SKIP_W-1:0] SKIP_MAX  = SKIP_W'(MAX_SKIP);
  localparam logic [SKIP_W-1:0] SKIP_ONE  = SKIP_W'(1);
  localparam logic [TMO_W-1:0]  TMO_MAX   = TMO_W'(MCU_TMO);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(MCU_TMO - 1);
  localparam logic [TMO_W-1:0]  TMO_ONE   = TMO_W'(1);

  localparam logic [1:0] SEL_NONE = 2'd0;
  localparam logic [1:0] SEL_LCD  = 2'd1;
  localparam logic [1:0] SEL_WR   = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LCD  = 3'd1,
    S_WR   = 3'd2,
    S_REL  = 3'd3,
    S_MCU  = 3'd4,
    S_RECL = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic              mreq_meta_q;
  logic              mreq_s_q;
  logic              lcd_gnt_q, lcd_gnt_d;
  logic              wr_gnt_q, wr_gnt_d;
  logic              mcu_ack_q, mcu_ack_d;
  logic              psram_ctrl_q, psram_ctrl_d;
  logic [1:0]        eng_sel_q, eng_sel_d;
  logic [SKIP_W-1:0] skip_cnt_q, skip_cnt_d;
  logic [TURN_W-1:0] turn_cnt_q, turn_cnt_d;
  logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic              underrun_q, underrun_d;
  logic              underrun_set;

  assign lcd_gnt      = lcd_gnt_q;
  assign wr_gnt       = wr_gnt_q;
  assign MCU_ACK      = mcu_ack_q;
  assign psram_ctrl   = psram_ctrl_q;
  assign eng_sel      = eng_sel_q;
  assign lcd_underrun = underrun_q;

  // Two-flop synchroniser for the asynchronous MCU bus request.
  always_ff @(posedge SYS_CLK or negedge SYS_RSTn) begin
    if (!SYS_RSTn) begin
      mreq_meta_q <= 1'b0;
      mreq_s_q    <= 1'b0;
    end else begin
      mreq_meta_q <= MCU_REQ;
      mreq_s_q    <= mreq_meta_q;
    end
  end

  // Arbitration state, registered grants/ownership and their counters.
  always_ff @(posedge SYS_CLK or negedge SYS_RSTn) begin
    if (!SYS_RSTn) begin
      state_q      <= S_IDLE;
      lcd_gnt_q    <= 1'b0;
      wr_gnt_q     <= 1'b0;
      mcu_ack_q    <= 1'b0;
      psram_ctrl_q <= 1'b1;
      eng_sel_q    <= SEL_NONE;
      skip_cnt_q   <= '0;
      turn_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      lcd_gnt_q    <= lcd_gnt_d;
      wr_gnt_q     <= wr_gnt_d;
      mcu_ack_q    <= mcu_ack_d;
      psram_ctrl_q <= psram_ctrl_d;
      eng_sel_q    <= eng_sel_d;
      skip_cnt_q   <= skip_cnt_d;
      turn_cnt_q   <= turn_cnt_d;
    end
  end

  // Next-state logic. Grants follow the state by one cycle so IDLE always
  // separates two bursts; ownership edges move together with the state.
  always_comb begin
    state_d      = state_q;
    lcd_gnt_d    = lcd_gnt_q;
    wr_gnt_d     = wr_gnt_q;
    mcu_ack_d    = mcu_ack_q;
    psram_ctrl_d = psram_ctrl_q;
    eng_sel_d    = eng_sel_q;
    skip_cnt_d   = skip_cnt_q;
    turn_cnt_d   = '0;

    case (state_q)
      S_IDLE: begin
        if (!mreq_s_q) begin
          skip_cnt_d = '0;
        end
        if (mreq_s_q && (skip_cnt_q == SKIP_MAX)) begin
          // MCU has been skipped long enough: it goes next regardless.
          state_d      = S_REL;
          psram_ctrl_d = 1'b0;
        end else if (lcd_req) begin
          state_d = S_LCD;
          if (mreq_s_q) begin
            skip_cnt_d = skip_cnt_q + SKIP_ONE;
          end
        end else if (wr_req) begin
          state_d = S_WR;
          if (mreq_s_q) begin
            skip_cnt_d = skip_cnt_q + SKIP_ONE;
          end
        end else if (mreq_s_q) begin
          state_d      = S_REL;
          psram_ctrl_d = 1'b0;
        end
      end

      S_LCD: begin
        if (lcd_done) begin
          state_d   = S_IDLE;
          lcd_gnt_d = 1'b0;
          eng_sel_d = SEL_NONE;
        end else begin
          lcd_gnt_d = 1'b1;
          eng_sel_d = SEL_LCD;
        end
      end

      S_WR: begin
        if (wr_done) begin
          state_d   = S_IDLE;
          wr_gnt_d  = 1'b0;
          eng_sel_d = SEL_NONE;
        end else begin
          wr_gnt_d  = 1'b1;
          eng_sel_d = SEL_WR;
        end
      end

      S_REL: begin
        if (!mreq_s_q) begin
          // Request withdrawn before the handover completed.
          state_d = S_RECL;
        end else if (turn_cnt_q == TURN_LAST) begin
          state_d    = S_MCU;
          mcu_ack_d  = 1'b1;
          skip_cnt_d = '0;
        end else begin
          turn_cnt_d = turn_cnt_q + TURN_ONE;
        end
      end

      S_MCU: begin
        if (!mreq_s_q) begin
          state_d   = S_RECL;
          mcu_ack_d = 1'b0;
        end
      end

      S_RECL: begin
        if (turn_cnt_q == TURN_LAST) begin
          state_d      = S_IDLE;
          psram_ctrl_d = 1'b1;
        end else begin
          turn_cnt_d = turn_cnt_q + TURN_ONE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Underrun watchdog: counts MCU-owned cycles while the display is waiting.
  always_comb begin
    tmo_cnt_d    = '0;
    underrun_set = 1'b0;
    if (state_q == S_MCU) begin
      tmo_cnt_d = tmo_cnt_q;
      if (lcd_req && (tmo_cnt_q != TMO_MAX)) begin
        tmo_cnt_d = tmo_cnt_q + TMO_ONE;
        if (tmo_cnt_q == TMO_LAST) begin
          underrun_set = 1'b1;
        end
      end
    end
    if (underrun_set) begin
      underrun_d = 1'b1;
    end else if (underrun_clr) begin
      underrun_d = 1'b0;
    end else begin
      underrun_d = underrun_q;
    end
  end

  // Watchdog counter and sticky underrun flag.
  always_ff @(posedge SYS_CLK or negedge SYS_RSTn) begin
    if (!SYS_RSTn) begin
      tmo_cnt_q  <= '0;
      underrun_q <= 1'b0;
    end else begin
      tmo_cnt_q  <= tmo_cnt_d;
      underrun_q <= underrun_d;
    end
  end

endmodule

// File: tb/tb_psram_bus_arbiter.sv
// tb/tb_psram_bus_arbiter.sv - scoreboard bench for psram_bus_arbiter
module tb_psram_bus_arbiter;

  localparam int TURN_CYC = 4;
  localparam int MAX_SKIP = 8;
  localparam int MCU_TMO  = 16;

  // Output vector layout: {lcd_gnt, wr_gnt, MCU_ACK, psram_ctrl, eng_sel[1:0], lcd_underrun}
  localparam logic [6:0] IDLE_V = 7'b0001000;
  localparam logic [6:0] OFF_V  = 7'b0000000;
  localparam logic [6:0] LCD_V  = 7'b1001010;
  localparam logic [6:0] WR_V   = 7'b0101100;
  localparam logic [6:0] ACK_V  = 7'b0010000;
  localparam logic [6:0] UND    = 7'b0000001;

  logic       SYS_CLK = 1'b0;
  logic       SYS_RSTn = 1'b1;
  logic       lcd_req = 1'b0;
  logic       lcd_done = 1'b0;
  logic       wr_req = 1'b0;
  logic       wr_done = 1'b0;
  logic       MCU_REQ = 1'b0;
  logic       underrun_clr = 1'b0;
  logic       lcd_gnt;
  logic       wr_gnt;
  logic       MCU_ACK;
  logic       psram_ctrl;
  logic [1:0] eng_sel;
  logic       lcd_underrun;
  logic [6:0] vec;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int T;

  typedef struct {
    int         cyc;
    logic [6:0] v;
  } exp_t;

  exp_t expq[$];
  exp_t mon_e;
  logic [6:0] prev_v = IDLE_V;
  int last_ctrl_fall = -1000;
  int last_ack_fall = -1000;

  psram_bus_arbiter #(
    .TURN_CYC(TURN_CYC),
    .MAX_SKIP(MAX_SKIP),
    .MCU_TMO (MCU_TMO)
  ) dut (
    .SYS_CLK     (SYS_CLK),
    .SYS_RSTn    (SYS_RSTn),
    .lcd_req     (lcd_req),
    .lcd_gnt     (lcd_gnt),
    .lcd_done    (lcd_done),
    .wr_req      (wr_req),
    .wr_gnt      (wr_gnt),
    .wr_done     (wr_done),
    .MCU_REQ     (MCU_REQ),
    .MCU_ACK     (MCU_ACK),
    .psram_ctrl  (psram_ctrl),
    .eng_sel     (eng_sel),
    .lcd_underrun(lcd_underrun),
    .underrun_clr(underrun_clr)
  );

  assign vec = {lcd_gnt, wr_gnt, MCU_ACK, psram_ctrl, eng_sel, lcd_underrun};

  always #5 SYS_CLK = ~SYS_CLK;

  always @(posedge SYS_CLK) cyc <= cyc + 1;

  task automatic expect_at(input int c, input logic [6:0] v);
    exp_t e;
    e.cyc = c;
    e.v   = v;
    expq.push_back(e);
  endtask

  task automatic at(input int c);
    while (cyc < c) @(negedge SYS_CLK);
  endtask

  // Change monitor: every output change must match the next scoreboard entry.
  always @(negedge SYS_CLK) begin
    if (!SYS_RSTn) begin
      checks++;
      if (vec !== IDLE_V) begin
        failures++;
        $display("FAIL reset_state cyc=%0d got=%b want=%b", cyc, vec, IDLE_V);
      end
      prev_v = IDLE_V;
      last_ctrl_fall = -1000;
      last_ack_fall = -1000;
    end else begin
      checks++;
      if (psram_ctrl === 1'b1 && MCU_ACK === 1'b1) begin
        failures++;
        $display("FAIL ownership_overlap cyc=%0d got ctrl=1 ack=1 want not both", cyc);
      end
      if (prev_v[3] && !vec[3]) last_ctrl_fall = cyc;
      if (prev_v[4] && !vec[4]) last_ack_fall = cyc;
      if (!prev_v[4] && vec[4]) begin
        checks++;
        if (cyc - last_ctrl_fall < TURN_CYC) begin
          failures++;
          $display("FAIL turn_gap_ack cyc=%0d got gap=%0d want>=%0d", cyc, cyc - last_ctrl_fall, TURN_CYC);
        end
      end
      if (!prev_v[3] && vec[3]) begin
        checks++;
        if (cyc - last_ack_fall < TURN_CYC) begin
          failures++;
          $display("FAIL turn_gap_ctrl cyc=%0d got gap=%0d want>=%0d", cyc, cyc - last_ack_fall, TURN_CYC);
        end
      end
      if (vec !== prev_v) begin
        checks++;
        if (expq.size() == 0) begin
          failures++;
          $display("FAIL unexpected_change cyc=%0d got=%b want=%b", cyc, vec, prev_v);
        end else begin
          mon_e = expq.pop_front();
          if (mon_e.cyc != cyc || mon_e.v !== vec) begin
            failures++;
            $display("FAIL event cyc=%0d got=%b want cyc=%0d vec=%b", cyc, vec, mon_e.cyc, mon_e.v);
          end
        end
        prev_v = vec;
      end
    end
  end

  // Reset must take effect without waiting for a clock edge.
  always @(negedge SYS_RSTn) begin
    #1;
    checks++;
    if (vec !== IDLE_V) begin
      failures++;
      $display("FAIL async_reset t=%0t got=%b want=%b", $time, vec, IDLE_V);
    end
  end

  initial begin
    #1 SYS_RSTn = 1'b0;
    repeat (5) @(negedge SYS_CLK);
    SYS_RSTn = 1'b1;
    repeat (3) @(negedge SYS_CLK);

    // Simultaneous LCD and write requests: LCD first, write on next IDLE.
    T = cyc;
    lcd_req = 1'b1;
    wr_req  = 1'b1;
    expect_at(T + 2, LCD_V);
    at(T + 2);  lcd_req = 1'b0;
    at(T + 10); lcd_done = 1'b1;
    expect_at(T + 11, IDLE_V);
    expect_at(T + 13, WR_V);
    at(T + 11); lcd_done = 1'b0;
    at(T + 13); wr_req = 1'b0;
    at(T + 16); wr_done = 1'b1;
    expect_at(T + 17, IDLE_V);
    at(T + 17); wr_done = 1'b0;
    at(T + 20); lcd_done = 1'b1; wr_done = 1'b1;
    at(T + 21); lcd_done = 1'b0; wr_done = 1'b0;
    repeat (3) @(negedge SYS_CLK);

    // Full MCU handover and return, with a write request parked during MCU.
    T = cyc;
    MCU_REQ = 1'b1;
    expect_at(T + 3, OFF_V);
    expect_at(T + 8, ACK_V);
    at(T + 10); wr_req = 1'b1;
    at(T + 15); MCU_REQ = 1'b0;
    expect_at(T + 18, OFF_V);
    expect_at(T + 23, IDLE_V);
    expect_at(T + 25, WR_V);
    at(T + 25); wr_req = 1'b0;
    at(T + 27); wr_done = 1'b1;
    expect_at(T + 28, IDLE_V);
    at(T + 28); wr_done = 1'b0;
    repeat (3) @(negedge SYS_CLK);

    // Aborted handover: request withdrawn while pins are being released.
    T = cyc;
    MCU_REQ = 1'b1;
    expect_at(T + 3, OFF_V);
    at(T + 3); MCU_REQ = 1'b0;
    expect_at(T + 11, IDLE_V);
    at(T + 14);
    repeat (3) @(negedge SYS_CLK);

    // Starvation guard: eight FPGA grants while MCU waits, then MCU; also underrun.
    T = cyc;
    lcd_req = 1'b1;
    wr_req  = 1'b1;
    expect_at(T + 2, LCD_V);
    at(T + 2); MCU_REQ = 1'b1;
    at(T + 6); lcd_done = 1'b1;
    expect_at(T + 7, IDLE_V);
    at(T + 7); lcd_done = 1'b0;
    for (int k = 0; k < MAX_SKIP; k++) begin
      expect_at(T + 9 + 6 * k, LCD_V);
      expect_at(T + 13 + 6 * k, IDLE_V);
      at(T + 12 + 6 * k); lcd_done = 1'b1;
      at(T + 13 + 6 * k); lcd_done = 1'b0;
    end
    expect_at(T + 56, OFF_V);
    expect_at(T + 61, ACK_V);
    expect_at(T + 77, ACK_V | UND);
    at(T + 80); MCU_REQ = 1'b0;
    expect_at(T + 83, OFF_V | UND);
    expect_at(T + 88, IDLE_V | UND);
    expect_at(T + 90, LCD_V | UND);
    at(T + 90); lcd_req = 1'b0;
    at(T + 93); lcd_done = 1'b1;
    expect_at(T + 94, IDLE_V | UND);
    expect_at(T + 96, WR_V | UND);
    at(T + 94); lcd_done = 1'b0;
    at(T + 96); wr_req = 1'b0;
    at(T + 99); wr_done = 1'b1;
    expect_at(T + 100, IDLE_V | UND);
    at(T + 100); wr_done = 1'b0;
    at(T + 102); underrun_clr = 1'b1;
    expect_at(T + 103, IDLE_V);
    at(T + 103); underrun_clr = 1'b0;
    repeat (3) @(negedge SYS_CLK);

    // Underrun with a coincident clear (set wins), then reset during MCU ownership.
    T = cyc;
    MCU_REQ = 1'b1;
    expect_at(T + 3, OFF_V);
    expect_at(T + 8, ACK_V);
    at(T + 8);  lcd_req = 1'b1;
    expect_at(T + 24, ACK_V | UND);
    at(T + 23); underrun_clr = 1'b1;
    at(T + 24); underrun_clr = 1'b0;
    at(T + 30);
    #2;
    SYS_RSTn = 1'b0;
    MCU_REQ  = 1'b0;
    lcd_req  = 1'b0;
    at(T + 33);
    #2;
    SYS_RSTn = 1'b1;
    at(T + 40);

    checks++;
    if (expq.size() != 0) begin
      failures++;
      $display("FAIL pending_events got=%0d want=0", expq.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/psram_bus_arbiter.md
Name: psram_bus_arbiter

Overview:
- Owns the shared PSRAM pins and the PSRAM engine.
- Arbitrates three requesters:
  - LCD line-fetch port (display refill, deadline-critical).
  - Generic FPGA write port.
  - External MCU, which takes whole-bus ownership through the MCU_REQ/MCU_ACK handshake.
- Drives psram_ctrl, the pin-ownership enable used by the top level to tri-state PSRAM_CEn/CLK/SIO.
- Drives eng_sel, which steers the engine's command mux.

Parameters:
- TURN_CYC, 4, idle cycles between pin release/reclaim and the MCU_ACK edge (bus turnaround).
- MAX_SKIP, 8, consecutive FPGA grants allowed while an MCU request is pending before the MCU is forced next.
- MCU_TMO, 4096, MCU ownership cycles with lcd_req pending before the underrun flag sets.

Ports:
- SYS_CLK  in  1  system clock (100 MHz domain); single clock.
- SYS_RSTn  in  1  reset, asynchronous assert, active-low.
- lcd_req  in  1  LCD fetch request; level, held until granted.
- lcd_gnt  out  1  LCD grant; level, held until lcd_done.
- lcd_done  in  1  one-cycle pulse from the engine: LCD burst complete.
- wr_req  in  1  write-port request; level.
- wr_gnt  out  1  write-port grant; level.
- wr_done  in  1  one-cycle pulse: write burst complete.
- MCU_REQ  in  1  MCU bus request; asynchronous, level.
- MCU_ACK  out  1  MCU owns the bus while high.
- psram_ctrl  out  1  1 = FPGA drives the PSRAM pins; 0 = pins released.
- eng_sel  out  2  engine source select: 0 none, 1 LCD, 2 write.
- lcd_underrun  out  1  sticky flag; set on MCU timeout while lcd_req is pending.
- underrun_clr  in  1  synchronous clear for lcd_underrun.

Behaviour:
- Reset values (asynchronous on SYS_RSTn low):
  - lcd_gnt=0, wr_gnt=0, MCU_ACK=0, eng_sel=0, lcd_underrun=0.
  - psram_ctrl=1; FPGA owns the bus.
  - State=IDLE; skip_cnt=0; turn_cnt=0; tmo_cnt=0.
- MCU_REQ passes through a 2-flop synchroniser (reset 0) before any use, giving mreq_s. Synchroniser latency is 2 cycles.
- States: IDLE, LCD, WR, REL, MCU, RECL.
- IDLE: evaluates requests each cycle. Priority order:
  1. mreq_s and skip_cnt==MAX_SKIP -> REL.
  2. lcd_req -> LCD.
  3. wr_req -> WR.
  4. mreq_s -> REL.
- Grant timing:
  - Grant outputs are registered; the grant asserts the cycle after IDLE samples the request.
  - eng_sel changes in the same cycle as the grant.
- LCD / WR:
  - Hold the grant until the matching done pulse.
  - On done: drop the grant and eng_sel in the next cycle, return to IDLE.
  - IDLE is always visited for at least one cycle between grants.
  - Done pulses arriving in any other state are ignored.
- skip_cnt:
  - Increments (saturating at MAX_SKIP) on each LCD/WR grant issued while mreq_s=1.
  - Clears on entry to MCU.
  - Clears when mreq_s=0 in IDLE.
- REL (pin release):
  - psram_ctrl drops on entry.
  - Counts TURN_CYC cycles, then asserts MCU_ACK and goes to MCU.
  - If mreq_s falls during REL: go to RECL without asserting MCU_ACK.
- MCU:
  - MCU_ACK=1 and psram_ctrl=0.
  - When mreq_s=0: drop MCU_ACK next cycle and go to RECL.
  - FPGA requests are not granted in this state; MCU ownership is never revoked.
- RECL:
  - Counts TURN_CYC cycles with both psram_ctrl and MCU_ACK low.
  - Then sets psram_ctrl=1 and goes to IDLE.
- Invariant: psram_ctrl and MCU_ACK are never both 1. At least TURN_CYC cycles separate the fall of either signal and the rise of the other.
- Underrun detection:
  - tmo_cnt counts cycles in MCU while lcd_req=1; it resets outside MCU.
  - On reaching MCU_TMO, lcd_underrun sets and stays set.
  - underrun_clr clears the flag; if set and clear occur in the same cycle, set wins.
- Simultaneous lcd_req and wr_req in IDLE: LCD wins. wr_req stays pending and is served on the next IDLE visit if lcd_req is low.
- Reset mid-operation: all outputs return to reset values immediately. Any in-flight engine burst is abandoned; the engine is reset by the same signal.

Test Plan:
- Reset: SYS_RSTn low for 5 cycles, release -> psram_ctrl=1, all grants 0, MCU_ACK=0, eng_sel=0.
- Simultaneous request: lcd_req=wr_req=1 at cycle 0 -> lcd_gnt=1 and eng_sel=1 at cycle 2 (IDLE sample plus register). lcd_done at cycle 10 -> lcd_gnt=0 at cycle 11. wr_gnt=1 at cycle 13.
- MCU handover with TURN_CYC=4:
  - MCU_REQ rises at cycle 0 with the bus idle -> psram_ctrl falls at cycle 3, MCU_ACK rises at cycle 8.
  - MCU_REQ falls -> MCU_ACK falls 3 cycles later; psram_ctrl rises 5 cycles after that.
  - Check the invariant on every cycle.
- Starvation: lcd_req and wr_req held continuously with MCU_REQ=1 -> exactly 8 FPGA grants, then MCU_ACK asserts. FPGA grants resume only after MCU_REQ drops.
- Aborted handover: MCU_REQ pulses high for 3 cycles -> REL entered, MCU_ACK never asserts, psram_ctrl back to 1 after TURN_CYC cycles in RECL.
- Underrun with MCU_TMO=16: MCU owns the bus and lcd_req held -> lcd_underrun=1 after 16 cycles and stays set after the MCU releases. underrun_clr pulse -> 0. Also assert SYS_RSTn low during MCU ownership -> MCU_ACK=0 and psram_ctrl=1 asynchronously.
